// File: rtl/comparator_2bit_reg_pkg.sv
// Shared constants and outcome encoding for the registered 2-bit comparator.
package comparator_2bit_reg_pkg;

  localparam int OPW       = 2;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    OUT_LT = 2'd0,
    OUT_EQ = 2'd1,
    OUT_GT = 2'd2
  } outcome_e;

endpackage

// File: rtl/comparator_2bit_reg_if.sv
// Operand/result bundle between a compare requester (master) and the comparator (slave).
interface comparator_2bit_reg_if
  import comparator_2bit_reg_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             in_valid;
  logic [OPW-1:0]   a;
  logic [OPW-1:0]   b;
  logic             out_valid;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] gt_cnt;

  modport master (
    output in_valid, a, b,
    input  out_valid, lt, eq, gt, lt_cnt, eq_cnt, gt_cnt
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, lt, eq, gt, lt_cnt, eq_cnt, gt_cnt
  );

endinterface

// File: rtl/comparator_2bit_reg_cell.sv
// Combinational 2-bit magnitude compare built from two 1-bit slices, MSB deciding first.
module comparator_2bit_cell
  import comparator_2bit_reg_pkg::*;
(
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  output logic           o_lt,
  output logic           o_eq,
  output logic           o_gt
);

  logic [OPW-1:0] w_lt;
  logic [OPW-1:0] w_eq;
  logic [OPW-1:0] w_gt;

  assign w_lt = ~i_a & i_b;
  assign w_eq = ~(i_a ^ i_b);
  assign w_gt = i_a & ~i_b;

  // The LSB slice only matters when the MSB slice reports equality.
  assign o_gt = w_gt[1] | (w_eq[1] & w_gt[0]);
  assign o_lt = w_lt[1] | (w_eq[1] & w_lt[0]);
  assign o_eq = w_eq[1] & w_eq[0];

endmodule

// File: rtl/comparator_2bit_reg.sv
// Registered 2-bit comparator: one-cycle flag triple plus per-outcome saturating counters.
module comparator_2bit_reg
  import comparator_2bit_reg_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
)(
  input  logic                 clk,
  input  logic                 rst,
  comparator_2bit_reg_if.slave bus
);

  logic             w_lt;
  logic             w_eq;
  logic             w_gt;
  outcome_e         w_outcome;

  logic             r_valid;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;
  logic [CNT_W-1:0] r_lt_cnt;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_gt_cnt;

  comparator_2bit_cell u_cell (
    .i_a  (bus.a),
    .i_b  (bus.b),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_outcome = OUT_EQ;
    if (w_lt)
      w_outcome = OUT_LT;
    else if (w_gt)
      w_outcome = OUT_GT;
  end

  // Flags hold between accepted compares; only out_valid marks freshness.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_lt_cnt <= '0;
      r_eq_cnt <= '0;
      r_gt_cnt <= '0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_lt <= w_lt;
        r_eq <= w_eq;
        r_gt <= w_gt;
        case (w_outcome)
          OUT_LT:  r_lt_cnt <= satInc(r_lt_cnt);
          OUT_EQ:  r_eq_cnt <= satInc(r_eq_cnt);
          OUT_GT:  r_gt_cnt <= satInc(r_gt_cnt);
          default: ;
        endcase
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.lt        = r_lt;
  assign bus.eq        = r_eq;
  assign bus.gt        = r_gt;
  assign bus.lt_cnt    = r_lt_cnt;
  assign bus.eq_cnt    = r_eq_cnt;
  assign bus.gt_cnt    = r_gt_cnt;

endmodule

// File: tb/tb_comparator_2bit_reg.sv
// Bench for comparator_2bit_reg: two instances (8-bit and 2-bit counters) driven identically.
module tb_comparator_2bit_reg;
  import comparator_2bit_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  comparator_2bit_reg_if #(.CNT_W(8)) bus8 ();
  comparator_2bit_reg_if #(.CNT_W(2)) bus2 ();

  comparator_2bit_reg #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  comparator_2bit_reg #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit mValid, mLt, mEq, mGt;
  int mCnt [3];

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    bit         expLt;
    bit         expEq;
    bit         expGt;
  } vec_t;

  vec_t vecs [4];

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int satTo(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic checkOutput();
    checkVal("dut8.out_valid", int'(bus8.out_valid), int'(mValid));
    checkVal("dut8.lt", int'(bus8.lt), int'(mLt));
    checkVal("dut8.eq", int'(bus8.eq), int'(mEq));
    checkVal("dut8.gt", int'(bus8.gt), int'(mGt));
    checkVal("dut8.lt_cnt", int'(bus8.lt_cnt), satTo(mCnt[OUT_LT], 8));
    checkVal("dut8.eq_cnt", int'(bus8.eq_cnt), satTo(mCnt[OUT_EQ], 8));
    checkVal("dut8.gt_cnt", int'(bus8.gt_cnt), satTo(mCnt[OUT_GT], 8));
    checkVal("dut2.out_valid", int'(bus2.out_valid), int'(mValid));
    checkVal("dut2.lt", int'(bus2.lt), int'(mLt));
    checkVal("dut2.eq", int'(bus2.eq), int'(mEq));
    checkVal("dut2.gt", int'(bus2.gt), int'(mGt));
    checkVal("dut2.lt_cnt", int'(bus2.lt_cnt), satTo(mCnt[OUT_LT], 2));
    checkVal("dut2.eq_cnt", int'(bus2.eq_cnt), satTo(mCnt[OUT_EQ], 2));
    checkVal("dut2.gt_cnt", int'(bus2.gt_cnt), satTo(mCnt[OUT_GT], 2));
    if (bus8.out_valid)
      checkVal("dut8.one_hot", $countones({bus8.lt, bus8.eq, bus8.gt}), 1);
  endtask

  // Drive one cycle, advance the reference model, then compare.
  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] a, input logic [1:0] b);
    int ia = int'(a);
    int ib = int'(b);
    rst = r;
    bus8.in_valid = v; bus8.a = a; bus8.b = b;
    bus2.in_valid = v; bus2.a = a; bus2.b = b;
    @(posedge clk);
    #1;
    if (r) begin
      mValid = 0; mLt = 0; mEq = 0; mGt = 0;
      foreach (mCnt[i]) mCnt[i] = 0;
    end else if (v) begin
      mValid = 1;
      mLt = (ia < ib);
      mEq = (ia == ib);
      mGt = (ia > ib);
      if (ia < ib)       mCnt[OUT_LT]++;
      else if (ia == ib) mCnt[OUT_EQ]++;
      else               mCnt[OUT_GT]++;
    end else begin
      mValid = 0;
    end
    checkOutput();
  endtask

  initial begin
    foreach (mCnt[i]) mCnt[i] = 0;
    vecs[0] = '{a: 2'b00, b: 2'b01, expLt: 1, expEq: 0, expGt: 0};
    vecs[1] = '{a: 2'b01, b: 2'b01, expLt: 0, expEq: 1, expGt: 0};
    vecs[2] = '{a: 2'b00, b: 2'b10, expLt: 1, expEq: 0, expGt: 0};
    vecs[3] = '{a: 2'b11, b: 2'b01, expLt: 0, expEq: 0, expGt: 1};

    applyStimulus(1, 0, 2'b00, 2'b00);
    applyStimulus(1, 0, 2'b00, 2'b00);

    applyStimulus(0, 1, 2'b01, 2'b00);
    checkVal("first.gt", int'(bus8.gt), 1);
    checkVal("first.gt_cnt", int'(bus8.gt_cnt), 1);

    applyStimulus(1, 0, 2'b00, 2'b00);
    foreach (vecs[i]) begin
      applyStimulus(0, 1, vecs[i].a, vecs[i].b);
      checkVal("table.lt", int'(bus8.lt), int'(vecs[i].expLt));
      checkVal("table.eq", int'(bus8.eq), int'(vecs[i].expEq));
      checkVal("table.gt", int'(bus8.gt), int'(vecs[i].expGt));
    end
    checkVal("b2b.lt_cnt", int'(bus8.lt_cnt), 2);
    checkVal("b2b.eq_cnt", int'(bus8.eq_cnt), 1);
    checkVal("b2b.gt_cnt", int'(bus8.gt_cnt), 1);

    applyStimulus(1, 0, 2'b00, 2'b00);
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        applyStimulus(0, 1, 2'(ia), 2'(ib));
    checkVal("sweep.eq_cnt", int'(bus8.eq_cnt), 4);
    checkVal("sweep.lt_cnt", int'(bus8.lt_cnt), 6);
    checkVal("sweep.gt_cnt", int'(bus8.gt_cnt), 6);

    applyStimulus(0, 1, 2'b10, 2'b01);
    applyStimulus(0, 0, 2'b00, 2'b11);
    checkVal("idle.out_valid", int'(bus8.out_valid), 0);
    checkVal("idle.gt_hold", int'(bus8.gt), 1);
    applyStimulus(0, 0, 2'b01, 2'b10);
    checkVal("idle.gt_cnt_hold", int'(bus8.gt_cnt), 7);

    applyStimulus(1, 0, 2'b00, 2'b00);
    for (int k = 0; k < 5; k++)
      applyStimulus(0, 1, 2'b11, 2'b11);
    checkVal("sat.eq_cnt", int'(bus2.eq_cnt), 3);
    checkVal("sat.lt_cnt", int'(bus2.lt_cnt), 0);
    checkVal("sat.gt_cnt", int'(bus2.gt_cnt), 0);
    checkVal("sat.eq_cnt8", int'(bus8.eq_cnt), 5);

    applyStimulus(1, 1, 2'b00, 2'b11);
    checkVal("rstpri.valid", int'(bus8.out_valid), 0);
    checkVal("rstpri.lt", int'(bus8.lt), 0);
    checkVal("rstpri.lt_cnt", int'(bus8.lt_cnt), 0);
    applyStimulus(0, 1, 2'b10, 2'b10);
    checkVal("rstpri.eq_after", int'(bus8.eq), 1);

    for (int n = 0; n < 400; n++)
      applyStimulus(($urandom_range(39) == 0), ($urandom_range(3) != 0),
                    2'($urandom_range(3)), 2'($urandom_range(3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
